// File: rtl/multi_issue_decode_stage.sv
// Multi-lane decode stage: splits a halfword window into up to LANES RV32/RVC
// instructions, decodes them and registers the group behind a valid/ready handshake.

package Decoder;

    typedef enum logic [5:0] {
        Op_None   = 6'd0,
        Op_Lui    = 6'd1,
        Op_Auipc  = 6'd2,
        Op_Jal    = 6'd3,
        Op_Jalr   = 6'd4,
        Op_Branch = 6'd5,
        Op_Load   = 6'd6,
        Op_Store  = 6'd7,
        Op_Addi   = 6'd8,
        Op_Slti   = 6'd9,
        Op_Sltiu  = 6'd10,
        Op_Xori   = 6'd11,
        Op_Ori    = 6'd12,
        Op_Andi   = 6'd13,
        Op_Slli   = 6'd14,
        Op_Srli   = 6'd15,
        Op_Srai   = 6'd16,
        Op_Add    = 6'd17,
        Op_Sub    = 6'd18,
        Op_Sll    = 6'd19,
        Op_Slt    = 6'd20,
        Op_Sltu   = 6'd21,
        Op_Xor    = 6'd22,
        Op_Srl    = 6'd23,
        Op_Sra    = 6'd24,
        Op_Or     = 6'd25,
        Op_And    = 6'd26,
        Op_Fence  = 6'd27,
        Op_Ecall  = 6'd28,
        Op_Ebreak = 6'd29
    } Op;

    typedef enum logic [4:0] {
        ExceptionCode_InsnMisaligned  = 5'd0,
        ExceptionCode_InsnAccessFault = 5'd1,
        ExceptionCode_IllegalInsn     = 5'd2,
        ExceptionCode_Breakpoint      = 5'd3,
        ExceptionCode_EcallM          = 5'd11,
        ExceptionCode_InsnPageFault   = 5'd12,
        ExceptionCode_LoadPageFault   = 5'd13,
        ExceptionCode_StorePageFault  = 5'd15
    } ExceptionCode;

    typedef struct packed {
        Op    op;
        logic isUnknown;
    } DecodeResult;

    function automatic DecodeResult Decode(input logic [31:0] insn);
        DecodeResult r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = insn[14:12];
        f7 = insn[31:25];
        r.op = Op_None;
        r.isUnknown = 1'b0;
        case (insn[6:0])
            7'b0110111: r.op = Op_Lui;
            7'b0010111: r.op = Op_Auipc;
            7'b1101111: r.op = Op_Jal;
            7'b1100111: if (f3 == 3'b000) r.op = Op_Jalr; else r.isUnknown = 1'b1;
            7'b1100011: if (f3 inside {3'b010, 3'b011}) r.isUnknown = 1'b1; else r.op = Op_Branch;
            7'b0000011: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) r.op = Op_Load;
                        else r.isUnknown = 1'b1;
            7'b0100011: if (f3 inside {3'b000, 3'b001, 3'b010}) r.op = Op_Store;
                        else r.isUnknown = 1'b1;
            7'b0010011: begin
                case (f3)
                    3'b000: r.op = Op_Addi;
                    3'b010: r.op = Op_Slti;
                    3'b011: r.op = Op_Sltiu;
                    3'b100: r.op = Op_Xori;
                    3'b110: r.op = Op_Ori;
                    3'b111: r.op = Op_Andi;
                    3'b001: if (f7 == 7'h00) r.op = Op_Slli; else r.isUnknown = 1'b1;
                    default: begin
                        if (f7 == 7'h00)      r.op = Op_Srli;
                        else if (f7 == 7'h20) r.op = Op_Srai;
                        else                  r.isUnknown = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                case ({f7, f3})
                    {7'h00, 3'b000}: r.op = Op_Add;
                    {7'h20, 3'b000}: r.op = Op_Sub;
                    {7'h00, 3'b001}: r.op = Op_Sll;
                    {7'h00, 3'b010}: r.op = Op_Slt;
                    {7'h00, 3'b011}: r.op = Op_Sltu;
                    {7'h00, 3'b100}: r.op = Op_Xor;
                    {7'h00, 3'b101}: r.op = Op_Srl;
                    {7'h20, 3'b101}: r.op = Op_Sra;
                    {7'h00, 3'b110}: r.op = Op_Or;
                    {7'h00, 3'b111}: r.op = Op_And;
                    default:         r.isUnknown = 1'b1;
                endcase
            end
            7'b0001111: r.op = Op_Fence;
            7'b1110011: begin
                if (insn == 32'h0000_0073)      r.op = Op_Ecall;
                else if (insn == 32'h0010_0073) r.op = Op_Ebreak;
                else                            r.isUnknown = 1'b1;
            end
            default: r.isUnknown = 1'b1;
        endcase
        return r;
    endfunction

    // Compressed encodings map onto the Op of their 32-bit expansion.
    function automatic DecodeResult DecodeRvc(input logic [15:0] half);
        DecodeResult r;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        f3  = half[15:13];
        rd  = half[11:7];
        rs2 = half[6:2];
        r.op = Op_None;
        r.isUnknown = 1'b0;
        case (half[1:0])
            2'b00: begin
                case (f3)
                    3'b000: if (half[12:5] != 8'h00) r.op = Op_Addi; else r.isUnknown = 1'b1;
                    3'b010: r.op = Op_Load;
                    3'b110: r.op = Op_Store;
                    default: r.isUnknown = 1'b1;
                endcase
            end
            2'b01: begin
                case (f3)
                    3'b000, 3'b010: r.op = Op_Addi;
                    3'b001, 3'b101: r.op = Op_Jal;
                    3'b011: begin
                        if ({half[12], half[6:2]} == 6'h00) r.isUnknown = 1'b1;
                        else if (rd == 5'd2)                r.op = Op_Addi;
                        else                                r.op = Op_Lui;
                    end
                    3'b100: begin
                        case (half[11:10])
                            2'b00: if (half[12]) r.isUnknown = 1'b1; else r.op = Op_Srli;
                            2'b01: if (half[12]) r.isUnknown = 1'b1; else r.op = Op_Srai;
                            2'b10: r.op = Op_Andi;
                            default: begin
                                if (half[12]) r.isUnknown = 1'b1;
                                else begin
                                    case (half[6:5])
                                        2'b00:   r.op = Op_Sub;
                                        2'b01:   r.op = Op_Xor;
                                        2'b10:   r.op = Op_Or;
                                        default: r.op = Op_And;
                                    endcase
                                end
                            end
                        endcase
                    end
                    default: r.op = Op_Branch;
                endcase
            end
            2'b10: begin
                case (f3)
                    3'b000: if (half[12]) r.isUnknown = 1'b1; else r.op = Op_Slli;
                    3'b010: if (rd == 5'd0) r.isUnknown = 1'b1; else r.op = Op_Load;
                    3'b110: r.op = Op_Store;
                    3'b100: begin
                        if (!half[12]) begin
                            if (rs2 != 5'd0)     r.op = Op_Add;
                            else if (rd != 5'd0) r.op = Op_Jalr;
                            else                 r.isUnknown = 1'b1;
                        end else begin
                            if (rd == 5'd0 && rs2 == 5'd0) r.op = Op_Ebreak;
                            else if (rs2 == 5'd0)          r.op = Op_Jalr;
                            else                           r.op = Op_Add;
                        end
                    end
                    default: r.isUnknown = 1'b1;
                endcase
            end
            default: r.isUnknown = 1'b1;
        endcase
        return r;
    endfunction

endpackage

module multi_issue_decode_stage #(
    parameter int LANES  = 2,
    parameter int WINDOW = 2 * LANES,
    parameter bit RVC_EN = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           flush,
    input  logic [$clog2(WINDOW+1)-1:0]                    inCount,
    input  logic [WINDOW*16-1:0]                           inHalf,
    input  logic [WINDOW-1:0]                              inFault,
    input  logic [31:0]                                    inPc,
    output logic [$clog2(WINDOW+1)-1:0]                    consume,
    input  logic                                           outReady,
    output logic [LANES-1:0]                               outValid,
    output logic [LANES*32-1:0]                            outPc,
    output logic [LANES*32-1:0]                            outInsn,
    output logic [LANES-1:0]                               outCompressed,
    output logic [LANES*$bits(Decoder::Op)-1:0]            outOp,
    output logic [LANES-1:0]                               outTrapValid,
    output logic [LANES*$bits(Decoder::ExceptionCode)-1:0] outTrapCause,
    output logic [LANES*32-1:0]                            outTrapValue
);

    localparam int CW  = $clog2(WINDOW + 1);
    localparam int IW  = $clog2(WINDOW);
    localparam int OPW = $bits(Decoder::Op);
    localparam int ECW = $bits(Decoder::ExceptionCode);

    logic [15:0]                     slot_half [WINDOW];
    logic [CW-1:0]                   count_eff;

    logic [LANES-1:0]                scan_valid;
    logic [LANES-1:0][31:0]          scan_pc;
    logic [LANES-1:0][31:0]          scan_insn;
    logic [LANES-1:0]                scan_comp;
    logic [LANES-1:0][OPW-1:0]       scan_op;
    logic [LANES-1:0]                scan_trap;
    logic [LANES-1:0][ECW-1:0]       scan_cause;
    logic [LANES-1:0][31:0]          scan_value;
    logic [CW-1:0]                   scan_len;

    logic [CW-1:0]                   off;
    logic [CW-1:0]                   off_hi;
    logic [CW:0]                     end_pos;
    logic                            stop;
    logic                            is32;
    logic [15:0]                     lo_half;
    logic [15:0]                     hi_half;
    logic [31:0]                     lane_insn;
    logic [31:0]                     lane_pc;
    logic                            fault_lo;
    logic                            fault_hi;
    logic                            illegal;
    Decoder::DecodeResult            dec32;
    Decoder::DecodeResult            dec16;

    logic                            load;

    logic [LANES-1:0]                valid_d,  valid_q;
    logic [LANES-1:0][31:0]          pc_d,     pc_q;
    logic [LANES-1:0][31:0]          insn_d,   insn_q;
    logic [LANES-1:0]                comp_d,   comp_q;
    logic [LANES-1:0][OPW-1:0]       op_d,     op_q;
    logic [LANES-1:0]                trap_d,   trap_q;
    logic [LANES-1:0][ECW-1:0]       cause_d,  cause_q;
    logic [LANES-1:0][31:0]          value_d,  value_q;

    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            slot_half[k] = inHalf[16*k +: 16];
        end
        count_eff = (inCount > CW'(WINDOW)) ? CW'(WINDOW) : inCount;
    end

    // Lanes are peeled off in order; the first lane that does not fit or that
    // traps closes the group, so valid lanes stay contiguous from lane 0.
    always_comb begin
        scan_valid = '0;
        scan_pc    = '0;
        scan_insn  = '0;
        scan_comp  = '0;
        scan_op    = '0;
        scan_trap  = '0;
        scan_cause = '0;
        scan_value = '0;
        off        = '0;
        stop       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            off_hi    = off + CW'(1);
            lo_half   = slot_half[off[IW-1:0]];
            hi_half   = slot_half[off_hi[IW-1:0]];
            is32      = (lo_half[1:0] == 2'b11);
            end_pos   = {1'b0, off} + (is32 ? (CW+1)'(2) : (CW+1)'(1));
            lane_insn = is32 ? {hi_half, lo_half} : {16'h0000, lo_half};
            lane_pc   = inPc + 32'({off, 1'b0});
            fault_lo  = inFault[off[IW-1:0]];
            fault_hi  = is32 && inFault[off_hi[IW-1:0]];
            dec32     = Decoder::Decode({hi_half, lo_half});
            dec16     = Decoder::DecodeRvc(lo_half);
            illegal   = is32 ? dec32.isUnknown
                             : ((lo_half == 16'h0000) || !RVC_EN || dec16.isUnknown);
            if (!stop && (end_pos <= {1'b0, count_eff})) begin
                scan_valid[i] = 1'b1;
                scan_pc[i]    = lane_pc;
                scan_insn[i]  = lane_insn;
                scan_comp[i]  = !is32;
                if (fault_lo || fault_hi) begin
                    scan_trap[i]  = 1'b1;
                    scan_cause[i] = Decoder::ExceptionCode_InsnPageFault;
                    scan_value[i] = fault_lo ? lane_pc : inPc + 32'({off_hi, 1'b0});
                    stop          = 1'b1;
                end else if (illegal) begin
                    scan_trap[i]  = 1'b1;
                    scan_cause[i] = Decoder::ExceptionCode_IllegalInsn;
                    scan_value[i] = lane_insn;
                    stop          = 1'b1;
                end else begin
                    scan_op[i]    = is32 ? dec32.op : dec16.op;
                end
                off = end_pos[CW-1:0];
            end else begin
                stop = 1'b1;
            end
        end
        scan_len = off;
    end

    assign load    = !(|valid_q) || outReady;
    assign consume = (rst && load && !flush) ? scan_len : '0;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        comp_d  = comp_q;
        op_d    = op_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        value_d = value_q;
        if (flush) begin
            valid_d = '0;
            pc_d    = '0;
            insn_d  = '0;
            comp_d  = '0;
            op_d    = '0;
            trap_d  = '0;
            cause_d = '0;
            value_d = '0;
        end else if (load) begin
            valid_d = scan_valid;
            pc_d    = scan_pc;
            insn_d  = scan_insn;
            comp_d  = scan_comp;
            op_d    = scan_op;
            trap_d  = scan_trap;
            cause_d = scan_cause;
            value_d = scan_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            pc_q    <= '0;
            insn_q  <= '0;
            comp_q  <= '0;
            op_q    <= '0;
            trap_q  <= '0;
            cause_q <= '0;
            value_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            comp_q  <= comp_d;
            op_q    <= op_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            value_q <= value_d;
        end
    end

    assign outValid      = valid_q;
    assign outPc         = pc_q;
    assign outInsn       = insn_q;
    assign outCompressed = comp_q;
    assign outOp         = op_q;
    assign outTrapValid  = trap_q;
    assign outTrapCause  = cause_q;
    assign outTrapValue  = value_q;

endmodule

// File: tb/tb_multi_issue_decode_stage.sv
// Directed bench for multi_issue_decode_stage: expected groups are queued at
// issue time and popped by per-DUT monitors one cycle later.

module tb_multi_issue_decode_stage;

    localparam int LANES = 2;
    localparam int WINDOW = 4;
    localparam int CW = 3;
    localparam int OPW = $bits(Decoder::Op);
    localparam int ECW = $bits(Decoder::ExceptionCode);

    typedef struct {
        logic [1:0]       valid;
        logic [63:0]      pc;
        logic [63:0]      insn;
        logic [1:0]       comp;
        logic [2*OPW-1:0] op;
        logic [1:0]       trap;
        logic [2*ECW-1:0] cause;
        logic [63:0]      value;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [CW-1:0] inCount = '0;
    logic [63:0] inHalf = '0;
    logic [3:0] inFault = '0;
    logic [31:0] inPc = 32'h1000;
    logic outReady = 1'b1;

    logic [CW-1:0] consume1, consume2;
    logic [1:0] outValid1, outValid2;
    logic [63:0] outPc1, outPc2, outInsn1, outInsn2, outTrapValue1, outTrapValue2;
    logic [1:0] outCompressed1, outCompressed2, outTrapValid1, outTrapValid2;
    logic [2*OPW-1:0] outOp1, outOp2;
    logic [2*ECW-1:0] outTrapCause1, outTrapCause2;

    int assertCount = 0;
    int failCount = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t mon1, mon2;

    always #5 clk = ~clk;

    multi_issue_decode_stage #(.LANES(LANES), .WINDOW(WINDOW), .RVC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .inCount(inCount), .inHalf(inHalf),
        .inFault(inFault), .inPc(inPc), .consume(consume1), .outReady(outReady),
        .outValid(outValid1), .outPc(outPc1), .outInsn(outInsn1),
        .outCompressed(outCompressed1), .outOp(outOp1), .outTrapValid(outTrapValid1),
        .outTrapCause(outTrapCause1), .outTrapValue(outTrapValue1)
    );

    multi_issue_decode_stage #(.LANES(LANES), .WINDOW(WINDOW), .RVC_EN(1'b0)) dutNoRvc (
        .clk(clk), .rst(rst), .flush(flush), .inCount(inCount), .inHalf(inHalf),
        .inFault(inFault), .inPc(inPc), .consume(consume2), .outReady(outReady),
        .outValid(outValid2), .outPc(outPc2), .outInsn(outInsn2),
        .outCompressed(outCompressed2), .outOp(outOp2), .outTrapValid(outTrapValid2),
        .outTrapCause(outTrapCause2), .outTrapValue(outTrapValue2)
    );

    function automatic exp_t emptyRec();
        exp_t r;
        r.valid = '0; r.pc = '0; r.insn = '0; r.comp = '0;
        r.op = '0; r.trap = '0; r.cause = '0; r.value = '0;
        return r;
    endfunction

    function automatic exp_t setLane(exp_t r, int lane, logic [31:0] pc, logic [31:0] insn,
                                     logic comp, logic [OPW-1:0] op, logic trap,
                                     logic [ECW-1:0] cause, logic [31:0] value);
        exp_t o;
        o = r;
        o.valid[lane] = 1'b1;
        o.pc[lane*32 +: 32] = pc;
        o.insn[lane*32 +: 32] = insn;
        o.comp[lane] = comp;
        o.op[lane*OPW +: OPW] = op;
        o.trap[lane] = trap;
        o.cause[lane*ECW +: ECW] = cause;
        o.value[lane*32 +: 32] = value;
        return o;
    endfunction

    task automatic compareField(input string tag, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic [1:0] v,
                               input logic [63:0] pc, input logic [63:0] insn,
                               input logic [1:0] comp, input logic [2*OPW-1:0] op,
                               input logic [1:0] trap, input logic [2*ECW-1:0] cause,
                               input logic [63:0] value);
        compareField(tag, "valid", 64'(v), 64'(e.valid));
        compareField(tag, "pc", pc, e.pc);
        compareField(tag, "insn", insn, e.insn);
        compareField(tag, "compressed", 64'(comp), 64'(e.comp));
        compareField(tag, "op", 64'(op), 64'(e.op));
        compareField(tag, "trapValid", 64'(trap), 64'(e.trap));
        compareField(tag, "trapCause", 64'(cause), 64'(e.cause));
        compareField(tag, "trapValue", value, e.value);
    endtask

    task automatic applyStimulus(input logic [CW-1:0] cnt, input logic [63:0] halves,
                                 input logic [3:0] fault, input logic ready, input logic fl,
                                 input logic [CW-1:0] expConsume, input exp_t e);
        @(negedge clk);
        inCount = cnt;
        inHalf = halves;
        inFault = fault;
        outReady = ready;
        flush = fl;
        #1;
        compareField("dut", "consume", 64'(consume1), 64'(expConsume));
        q1.push_back(e);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q1.size() != 0) begin
            mon1 = q1.pop_front();
            checkOutput("dut", mon1, outValid1, outPc1, outInsn1, outCompressed1, outOp1,
                        outTrapValid1, outTrapCause1, outTrapValue1);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (q2.size() != 0) begin
            mon2 = q2.pop_front();
            checkOutput("dutNoRvc", mon2, outValid2, outPc2, outInsn2, outCompressed2, outOp2,
                        outTrapValid2, outTrapCause2, outTrapValue2);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] w1, w0, w4, wStraddle;
        exp_t e1, e2, e3, e4, e4b, eBubble, e6, eS2, eS3;
        logic [OPW-1:0] opAddi;
        opAddi = Decoder::Op_Addi;

        w1 = {16'h0001, 16'h0085, 16'h0010, 16'h0093};
        w0 = 64'h0;
        w4 = {16'h0000, 16'h0000, 16'h0001, 16'h0085};
        wStraddle = {16'h0000, 16'h0010, 16'h0093, 16'h0001};

        eBubble = emptyRec();
        e1 = setLane(emptyRec(), 0, 32'h1000, 32'h0010_0093, 1'b0, opAddi, 1'b0, 5'd0, 32'h0);
        e1 = setLane(e1, 1, 32'h1004, 32'h0000_0085, 1'b1, opAddi, 1'b0, 5'd0, 32'h0);
        e2 = setLane(emptyRec(), 0, 32'h1000, 32'h0010_0093, 1'b0, '0, 1'b1, 5'd12, 32'h1002);
        e3 = setLane(emptyRec(), 0, 32'h1000, 32'h0, 1'b1, '0, 1'b1, 5'd2, 32'h0);
        e4 = setLane(emptyRec(), 0, 32'h1000, 32'h85, 1'b1, opAddi, 1'b0, 5'd0, 32'h0);
        e4 = setLane(e4, 1, 32'h1002, 32'h1, 1'b1, opAddi, 1'b0, 5'd0, 32'h0);
        e4b = setLane(emptyRec(), 0, 32'h1000, 32'h85, 1'b1, '0, 1'b1, 5'd2, 32'h85);
        e6 = setLane(emptyRec(), 0, 32'h1000, 32'h0010_0093, 1'b0, opAddi, 1'b0, 5'd0, 32'h0);
        eS2 = setLane(emptyRec(), 0, 32'h1000, 32'h1, 1'b1, opAddi, 1'b0, 5'd0, 32'h0);
        eS3 = setLane(eS2, 1, 32'h1002, 32'h0010_0093, 1'b0, opAddi, 1'b0, 5'd0, 32'h0);

        // Hold reset with a live window across a clock edge.
        inCount = 3'd4;
        inHalf = w1;
        #12;
        compareField("reset", "valid", 64'(outValid1), 64'h0);
        compareField("reset", "pc", outPc1, 64'h0);
        compareField("reset", "insn", outInsn1, 64'h0);
        compareField("reset", "op", 64'(outOp1), 64'h0);
        compareField("reset", "consume", 64'(consume1), 64'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        compareField("dut", "consume", 64'(consume1), 64'd3);
        q1.push_back(e1);

        applyStimulus(3'd4, w1, 4'b0010, 1'b1, 1'b0, 3'd2, e2);
        applyStimulus(3'd4, w0, 4'b0000, 1'b1, 1'b0, 3'd1, e3);
        applyStimulus(3'd4, w4, 4'b0000, 1'b1, 1'b0, 3'd2, e4);
        compareField("dutNoRvc", "consume", 64'(consume2), 64'd1);
        q2.push_back(e4b);

        applyStimulus(3'd1, w1, 4'b0000, 1'b1, 1'b0, 3'd0, eBubble);
        applyStimulus(3'd2, w1, 4'b0000, 1'b1, 1'b0, 3'd2, e6);
        applyStimulus(3'd2, wStraddle, 4'b0000, 1'b1, 1'b0, 3'd1, eS2);
        applyStimulus(3'd3, wStraddle, 4'b0000, 1'b1, 1'b0, 3'd3, eS3);

        applyStimulus(3'd4, w1, 4'b0000, 1'b1, 1'b0, 3'd3, e1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd4, w0, 4'b0000, 1'b0, 1'b0, 3'd0, e1);
        end
        applyStimulus(3'd4, w4, 4'b0000, 1'b1, 1'b0, 3'd2, e4);

        applyStimulus(3'd4, w1, 4'b0000, 1'b1, 1'b0, 3'd3, e1);
        applyStimulus(3'd4, w1, 4'b0000, 1'b1, 1'b1, 3'd0, eBubble);
        applyStimulus(3'd4, w1, 4'b0000, 1'b0, 1'b0, 3'd3, e1);
        applyStimulus(3'd4, w1, 4'b0000, 1'b0, 1'b0, 3'd0, e1);

        // Asynchronous reset between edges while a group is held.
        @(posedge clk);
        #3;
        flush = 1'b0;
        compareField("preReset", "valid", 64'(outValid1), 64'h3);
        rst = 1'b0;
        #1;
        compareField("asyncReset", "valid", 64'(outValid1), 64'h0);
        compareField("asyncReset", "pc", outPc1, 64'h0);
        compareField("asyncReset", "insn", outInsn1, 64'h0);
        compareField("asyncReset", "consume", 64'(consume1), 64'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        compareField("dut", "consume", 64'(consume1), 64'd3);
        q1.push_back(e1);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        compareField("drain", "pending", 64'(q1.size() + q2.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
